// File: rtl/controle_senha.sv
// Safe password controller: debounces the two buttons, latches switches as password/attempt, runs lock FSM.
// Macro COFRE_BLOQUEIO_EN enables attempt counting and the timed BLOQUEADO lockout.
module controle_senha #(
   parameter int DEBOUNCE_CICLOS = 500000,
   parameter int MAX_TENTATIVAS  = 3,
   parameter int BLOQUEIO_CICLOS = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] chaves,
   input  logic       botao_cadastrar,
   input  logic       botao_confirmar,
   output logic [3:0] senha_cadastrada,
   output logic [3:0] senha_tentativa,
   output logic       valido,
   output logic       aberto,
   output logic       bloqueado,
   output logic [1:0] tentativas_rest
);
   localparam int            CW     = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0] DB_FIM = CW'(DEBOUNCE_CICLOS - 1);
   localparam logic [1:0]    MAX_T  = 2'(MAX_TENTATIVAS);

   typedef enum logic [2:0] {VAZIO, FECHADO, VERIFICA, ABERTO, BLOQUEADO} estado_t;

   // Index 0 = cadastrar, index 1 = confirmar
   logic [1:0]    r_sync1, r_sync2, r_db, r_db_d;
   logic [CW-1:0] r_cnt [2];
   logic [1:0]    w_botao, w_pulso;
   logic          w_p_cad, w_p_conf;

   assign w_botao  = {botao_confirmar, botao_cadastrar};
   assign w_pulso  = r_db & ~r_db_d;
   assign w_p_cad  = w_pulso[0];
   assign w_p_conf = w_pulso[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_db     <= '0;
         r_db_d   <= '0;
         r_cnt[0] <= '0;
         r_cnt[1] <= '0;
      end else begin
         r_sync1 <= w_botao;
         r_sync2 <= r_sync1;
         r_db_d  <= r_db;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] != r_db[i]) begin
               if (r_cnt[i] == DB_FIM) begin
                  r_db[i]  <= r_sync2[i];
                  r_cnt[i] <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + CW'(1);
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   estado_t    r_estado, w_estado_prox;
   logic [3:0] r_senha, r_tent, w_senha_prox, w_tent_prox;
   logic [1:0] r_rest, w_rest_prox;
   logic       r_valido, r_aberto;
   logic       w_igual;

   assign w_igual = (r_tent == r_senha);

`ifdef COFRE_BLOQUEIO_EN
   localparam int            TW      = (BLOQUEIO_CICLOS > 1) ? $clog2(BLOQUEIO_CICLOS) : 1;
   localparam logic [TW-1:0] T_CARGA = TW'(BLOQUEIO_CICLOS - 1);

   logic [TW-1:0] r_timer, w_timer_prox;
   logic          r_bloq;
   logic [1:0]    w_rest_dec;

   // Saturating decrement so the counter can never wrap to 3
   assign w_rest_dec = (r_rest == 2'd0) ? 2'd0 : r_rest - 2'd1;
`endif

   always_comb begin
      w_estado_prox = r_estado;
      w_senha_prox  = r_senha;
      w_tent_prox   = r_tent;
      w_rest_prox   = r_rest;
`ifdef COFRE_BLOQUEIO_EN
      w_timer_prox  = r_timer;
`endif
      case (r_estado)
         VAZIO: begin
            if (w_p_cad) begin
               w_senha_prox  = chaves;
               w_rest_prox   = MAX_T;
               w_estado_prox = FECHADO;
            end
         end
         FECHADO: begin
            if (w_p_conf) begin
               w_tent_prox   = chaves;
               w_estado_prox = VERIFICA;
            end
         end
         VERIFICA: begin
            if (w_igual) begin
               w_rest_prox   = MAX_T;
               w_estado_prox = ABERTO;
            end else begin
`ifdef COFRE_BLOQUEIO_EN
               w_rest_prox = w_rest_dec;
               if (w_rest_dec == 2'd0) begin
                  w_timer_prox  = T_CARGA;
                  w_estado_prox = BLOQUEADO;
               end else begin
                  w_estado_prox = FECHADO;
               end
`else
               w_estado_prox = FECHADO;
`endif
            end
         end
         ABERTO: begin
            if (w_p_cad) begin
               w_senha_prox  = chaves;
               w_estado_prox = FECHADO;
            end else if (w_p_conf) begin
               w_estado_prox = FECHADO;
            end
         end
         BLOQUEADO: begin
`ifdef COFRE_BLOQUEIO_EN
            // Pulses are deliberately not looked at here, so none are queued
            if (r_timer == '0) begin
               w_rest_prox   = MAX_T;
               w_estado_prox = FECHADO;
            end else begin
               w_timer_prox = r_timer - TW'(1);
            end
`else
            w_estado_prox = FECHADO;
`endif
         end
         default: w_estado_prox = VAZIO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado <= VAZIO;
         r_senha  <= '0;
         r_tent   <= '0;
         r_rest   <= '0;
         r_valido <= 1'b0;
         r_aberto <= 1'b0;
`ifdef COFRE_BLOQUEIO_EN
         r_timer  <= '0;
         r_bloq   <= 1'b0;
`endif
      end else begin
         r_estado <= w_estado_prox;
         r_senha  <= w_senha_prox;
         r_tent   <= w_tent_prox;
         r_rest   <= w_rest_prox;
         r_valido <= (w_estado_prox == VERIFICA);
         r_aberto <= (w_estado_prox == ABERTO);
`ifdef COFRE_BLOQUEIO_EN
         r_timer  <= w_timer_prox;
         r_bloq   <= (w_estado_prox == BLOQUEADO);
`endif
      end
   end

   assign senha_cadastrada = r_senha;
   assign senha_tentativa  = r_tent;
   assign valido           = r_valido;
   assign aberto           = r_aberto;
   assign tentativas_rest  = r_rest;
`ifdef COFRE_BLOQUEIO_EN
   assign bloqueado        = r_bloq;
`else
   assign bloqueado        = 1'b0;
`endif

endmodule
